// File: rtl/ext_shift_unit_if.sv
// Request/response bundle of the iterative extender/shifter.
// Both directions use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface ext_shift_unit_if #(
   parameter int WORD_SIZE = 16,
   parameter int AMT_W     = $clog2(WORD_SIZE) + 1
);
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           mode;
   logic [AMT_W-1:0]     amount;
   logic [WORD_SIZE-1:0] data;
   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_SIZE-1:0] result;

   modport master (
      output in_valid, mode, amount, data, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, mode, amount, data, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/ext_shift_unit.sv
// Multicycle sign/zero extender and shifter: a LEFT phase then a RIGHT phase,
// each moving up to STEP bits per cycle through one working register.
module ext_shift_unit #(
   parameter int WORD_SIZE = 16,
   parameter int STEP      = 1,
   parameter int AMT_W     = $clog2(WORD_SIZE) + 1
) (
   input  logic               clk,
   input  logic               reset_n,
   ext_shift_unit_if.slave    bus,
   output logic [1:0]         dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LEFT  = 2'd1;
   localparam logic [1:0] S_RIGHT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] M_SEXT = 3'd0;
   localparam logic [2:0] M_ZEXT = 3'd1;
   localparam logic [2:0] M_SHL  = 3'd2;
   localparam logic [2:0] M_SHR  = 3'd3;
   localparam logic [2:0] M_SAR  = 3'd4;

   localparam logic [AMT_W-1:0] WS_A   = AMT_W'(WORD_SIZE);
   localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

   logic [1:0]           state;
   logic [WORD_SIZE-1:0] work;
   logic [2:0]           mode_q;
   logic [AMT_W-1:0]     rem_l;
   logic [AMT_W-1:0]     rem_r;

   logic                 accept;
   logic [AMT_W-1:0]     amt_c;
   logic [AMT_W-1:0]     n_l;
   logic [AMT_W-1:0]     n_r;
   logic [AMT_W-1:0]     rem_cur;
   logic [AMT_W-1:0]     step_n;
   logic [AMT_W-1:0]     rem_next;
   logic                 arith;
   logic [WORD_SIZE-1:0] shl_v;
   logic [WORD_SIZE-1:0] shr_v;

   assign accept        = bus.in_valid && (state == S_IDLE);
   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.result    = work;
   assign dbg_state     = state;

   // Extension is a left shift that parks the field at the MSB, then a right
   // shift back by the same count that fills with sign or zero.
   always_comb begin
      amt_c = (bus.amount > WS_A) ? WS_A : bus.amount;
      n_l   = '0;
      n_r   = '0;
      case (bus.mode)
         M_SEXT, M_ZEXT: begin
            n_l = WS_A - amt_c;
            n_r = WS_A - amt_c;
         end
         M_SHL:         n_l = amt_c;
         M_SHR, M_SAR:  n_r = amt_c;
         default:       ;
      endcase
   end

   // The last step of a phase only moves the remaining bits, never a full STEP.
   always_comb begin
      rem_cur  = (state == S_LEFT) ? rem_l : rem_r;
      step_n   = (rem_cur < STEP_A) ? rem_cur : STEP_A;
      rem_next = rem_cur - step_n;
      arith    = (mode_q == M_SEXT) || (mode_q == M_SAR);
      shl_v    = work << step_n;
      shr_v    = arith ? WORD_SIZE'($signed(work) >>> step_n) : (work >> step_n);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         work   <= '0;
         mode_q <= '0;
         rem_l  <= '0;
         rem_r  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  work   <= bus.data;
                  mode_q <= bus.mode;
                  rem_l  <= n_l;
                  rem_r  <= n_r;
                  if (n_l != '0)      state <= S_LEFT;
                  else if (n_r != '0) state <= S_RIGHT;
                  else                state <= S_DONE;
               end
            end
            S_LEFT: begin
               work  <= shl_v;
               rem_l <= rem_next;
               if (rem_next == '0) state <= (rem_r != '0) ? S_RIGHT : S_DONE;
            end
            S_RIGHT: begin
               work  <= shr_v;
               rem_r <= rem_next;
               if (rem_next == '0) state <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_shift_unit.sv
// Bench for ext_shift_unit: one STEP=1 and one STEP=4 instance share a driver,
// a negedge monitor checks latency and in-order results against expected queues.
module tb_ext_shift_unit;

   localparam int W     = 16;
   localparam int AMT_W = $clog2(W) + 1;

   logic clk;
   logic reset_n;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   logic             sel;
   logic             drv_valid;
   logic [2:0]       drv_mode;
   logic [AMT_W-1:0] drv_amount;
   logic [W-1:0]     drv_data;
   logic             drv_oready;
   logic [1:0]       dbg1;
   logic [1:0]       dbg4;

   ext_shift_unit_if #(.WORD_SIZE(W)) bus1 ();
   ext_shift_unit_if #(.WORD_SIZE(W)) bus4 ();

   assign bus1.in_valid  = drv_valid && !sel;
   assign bus4.in_valid  = drv_valid && sel;
   assign bus1.mode      = drv_mode;
   assign bus4.mode      = drv_mode;
   assign bus1.amount    = drv_amount;
   assign bus4.amount    = drv_amount;
   assign bus1.data      = drv_data;
   assign bus4.data      = drv_data;
   assign bus1.out_ready = sel ? 1'b1 : drv_oready;
   assign bus4.out_ready = sel ? drv_oready : 1'b1;

   ext_shift_unit #(.WORD_SIZE(W), .STEP(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .dbg_state(dbg1)
   );
   ext_shift_unit #(.WORD_SIZE(W), .STEP(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .bus(bus4.slave), .dbg_state(dbg4)
   );

   logic         m_in_valid, m_in_ready, m_ov, m_oready;
   logic [W-1:0] m_res;
   logic [1:0]   m_state;
   assign m_in_valid = sel ? bus4.in_valid  : bus1.in_valid;
   assign m_in_ready = sel ? bus4.in_ready  : bus1.in_ready;
   assign m_ov       = sel ? bus4.out_valid : bus1.out_valid;
   assign m_oready   = sel ? bus4.out_ready : bus1.out_ready;
   assign m_res      = sel ? bus4.result    : bus1.result;
   assign m_state    = sel ? dbg4 : dbg1;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   int           lat_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [W-1:0] mdl_res(input logic [2:0] m, input int amt, input logic [W-1:0] d);
      int a;
      logic [W-1:0] mask;
      a    = (amt > W) ? W : amt;
      mask = (a >= W) ? {W{1'b1}} : W'((32'd1 << a) - 32'd1);
      case (m)
         3'd0:    return (a == 0) ? '0 : (d[a-1] ? (d | ~mask) : (d & mask));
         3'd1:    return d & mask;
         3'd2:    return (a >= W) ? '0 : (d << a);
         3'd3:    return (a >= W) ? '0 : (d >> a);
         3'd4:    return (a >= W) ? {W{d[W-1]}} : W'($signed(d) >>> a);
         default: return d;
      endcase
   endfunction

   function automatic int mdl_lat(input logic [2:0] m, input int amt, input int s);
      int a, nl, nr;
      a  = (amt > W) ? W : amt;
      nl = 0;
      nr = 0;
      case (m)
         3'd0, 3'd1: begin nl = W - a; nr = W - a; end
         3'd2:       nl = a;
         3'd3, 3'd4: nr = a;
         default:    ;
      endcase
      return 1 + (nl + s - 1) / s + (nr + s - 1) / s;
   endfunction

   // ---------------- monitor ----------------
   int cyc = 0;
   int acc_cyc = 0;
   bit ov_seen = 0;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         ov_seen = 0;
      end else begin
         if (m_in_valid && m_in_ready) acc_cyc = cyc;
         if (m_ov && !ov_seen) begin
            ov_seen = 1;
            if (lat_q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
            else chk("latency", cyc - acc_cyc, lat_q.pop_front());
         end
         if (m_ov && m_oready) begin
            ov_seen = 0;
            if (exp_q.size() == 0) chk("spurious_result", 32'd1, 32'd0);
            else chk("result", 32'(m_res), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [2:0] m, input int amt, input logic [W-1:0] d,
                       input logic [W-1:0] er, input int el, input bit hold, output int waits);
      bit got;
      exp_q.push_back(er);
      lat_q.push_back(el);
      drv_mode   = m;
      drv_amount = AMT_W'(amt);
      drv_data   = d;
      drv_valid  = 1'b1;
      got   = 0;
      waits = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = m_in_ready;
         @(posedge clk);
         #1;
         waits++;
      end
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
      if (!hold) drv_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         #1;
         done = (exp_q.size() == 0) && m_in_ready;
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_model(input logic [2:0] m, input int amt, input logic [W-1:0] d, input int s);
      int w;
      send(m, amt, d, mdl_res(m, amt, d), mdl_lat(m, amt, s), 1'b0, w);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w, a0, a1, a2;
      reset_n    = 1'b0;
      sel        = 1'b0;
      drv_valid  = 1'b0;
      drv_mode   = '0;
      drv_amount = '0;
      drv_data   = '0;
      drv_oready = 1'b1;
      #1;
      chk("rst_in_ready1", 32'(bus1.in_ready), 32'd1);
      chk("rst_out_valid1", 32'(bus1.out_valid), 32'd0);
      chk("rst_result1", 32'(bus1.result), 32'd0);
      chk("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
      chk("rst_state4", 32'(dbg4), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // STEP=1 directed vectors
      send(3'd0, 8,  16'h00F3, 16'hFFF3, 17, 1'b0, w); drain();
      send(3'd1, 12, 16'hABCD, 16'h0BCD, 9,  1'b0, w); drain();
      send(3'd0, 0,  16'h5A5A, 16'h0000, 33, 1'b0, w); drain();
      send(3'd6, 5,  16'h1234, 16'h1234, 1,  1'b0, w); drain();
      send(3'd1, 16, 16'h8765, 16'h8765, 1,  1'b0, w); drain();
      for (int i = 0; i < 8; i++) begin
         send_model(3'($urandom_range(0, 7)), $urandom_range(0, 31), W'($urandom), 1);
         drain();
      end

      // back-pressure on the STEP=1 unit
      drv_oready = 1'b0;
      send(3'd2, 1, 16'h4001, 16'h8002, 2, 1'b0, w);
      for (int i = 0; i < 20 && !m_ov; i++) begin @(posedge clk); #1; end
      drv_mode = 3'd3; drv_amount = AMT_W'(4); drv_data = 16'hF0F0; drv_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(m_ov), 32'd1);
         chk("bp_result", 32'(m_res), 32'h8002);
         chk("bp_in_ready", 32'(m_in_ready), 32'd0);
         chk("bp_state", 32'(m_state), 32'd3);
         @(posedge clk);
         #1;
      end
      drv_oready = 1'b1;
      send(3'd3, 4, 16'hF0F0, 16'h0F0F, 5, 1'b0, w);
      chk("bp_release_accept_wait", w, 32'd2);
      drain();

      // asynchronous reset in the middle of a LEFT phase
      send(3'd0, 4, 16'h1234, 16'h0000, 0, 1'b0, w);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_state_left", 32'(m_state), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(m_ov), 32'd0);
      chk("arst_result", 32'(m_res), 32'd0);
      chk("arst_in_ready", 32'(m_in_ready), 32'd1);
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      send(3'd2, 1, 16'h4001, 16'h8002, 2, 1'b0, w); drain();

      // back-to-back with in_valid held high
      send(3'd2, 1, 16'h0001, 16'h0002, 2, 1'b1, w); a0 = acc_cyc;
      send(3'd2, 1, 16'h0300, 16'h0600, 2, 1'b1, w); a1 = acc_cyc;
      send(3'd2, 1, 16'hC003, 16'h8006, 2, 1'b0, w); a2 = acc_cyc;
      chk("b2b_interval1", a1 - a0, 32'd3);
      chk("b2b_interval2", a2 - a1, 32'd3);
      drain();

      // STEP=4 unit
      sel = 1'b1;
      @(posedge clk);
      #1;
      send(3'd4, 3,  16'h8010, 16'hF002, 2, 1'b0, w); drain();
      send(3'd2, 20, 16'h1234, 16'h0000, 5, 1'b0, w); drain();
      send(3'd3, 6,  16'hFFFF, 16'h03FF, 3, 1'b0, w); drain();
      send(3'd4, 16, 16'h8000, 16'hFFFF, 5, 1'b0, w); drain();
      send(3'd0, 5,  16'h0013, 16'hFFF3, 7, 1'b0, w); drain();
      for (int i = 0; i < 8; i++) begin
         send_model(3'($urandom_range(0, 7)), $urandom_range(0, 31), W'($urandom), 4);
         drain();
      end

      repeat (3) @(posedge clk);
      chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ext_shift_unit.md
# ext_shift_unit

Parametrised multicycle extender/shifter: a successor to the combinational immediate generator. It accepts one word plus a mode and an amount over a valid/ready handshake. It produces sign/zero-extension of an arbitrary-width low field, or a logical/arithmetic shift, by iterative shifting of STEP bits per cycle. It sits between decode and the ALU operand mux and is shared by immediate extension and variable shift instructions.

## Interface
- WORD_SIZE, 16: datapath width; must be ≥ 2.
- STEP, 1: bits shifted per cycle; 1..WORD_SIZE.
- AMT_W, $clog2(WORD_SIZE)+1: width of `amount`.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  unit idle; equals (state == IDLE).
- mode  in  3  0 SEXT, 1 ZEXT, 2 SHL, 3 SHR (logical), 4 SAR (arithmetic); 5–7 reserved (pass-through).
- amount  in  AMT_W  field width (SEXT/ZEXT) or shift count (shifts).
- data  in  WORD_SIZE  operand.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- result  out  WORD_SIZE  registered result.

## Operation
- **Accept:** accept when in_valid && in_ready. At that edge, latch data into the working register and latch mode. Clamp `amount` to a = min(amount, WORD_SIZE). Inputs are ignored at all other times.
- **Phase counts (nL, nR):**
  - SEXT/ZEXT: nL = nR = WORD_SIZE − a. The LEFT phase is a logical left shift. The RIGHT phase is arithmetic for SEXT and logical for ZEXT.
    - a = 0 gives result 0.
    - a = WORD_SIZE gives data unchanged.
  - SHL: nL = a, nR = 0.
  - SHR/SAR: nL = 0, nR = a, logical or arithmetic respectively.
  - Reserved modes: nL = nR = 0, so result = data.
- **FSM states:** IDLE, LEFT, RIGHT, DONE.
  - IDLE → on accept, go to LEFT if nL>0, else RIGHT if nR>0, else DONE.
  - LEFT/RIGHT: each cycle, shift by min(STEP, remaining) and decrement remaining. When remaining reaches 0, go to RIGHT if nR>0, else DONE.
  - DONE: hold result and out_valid. If out_ready, go to IDLE at the next edge.
- **Arithmetic fill:** the fill bit is the current MSB of the working register, re-sampled each cycle.
  - SAR by a ≥ WORD_SIZE therefore yields all sign bits.
  - SHL/SHR by a ≥ WORD_SIZE yield 0.
- **Result register:** `result` is the working register. It is only meaningful when out_valid = 1 and holds stable throughout DONE.
- **No overlap:** in_ready is low in LEFT, RIGHT and DONE. There is no accept in the DONE→IDLE cycle, so the minimum issue interval is 2 cycles.

## Timing
- **Reset (reset_n low, asynchronous):**
  - state = IDLE, result = 0, out_valid = 0, in_ready = 1, counters = 0.
  - Reset mid-operation aborts immediately; no result is produced.
- **Latency:** out_valid rises 1 + ceil(nL/STEP) + ceil(nR/STEP) cycles after the accept cycle. Zero-length phases cost 0 cycles, so the minimum is 1.
- **Back-pressure:** out_valid stays high and result stays stable for as long as out_ready is low. Any in_valid during this time is not accepted.
- **Release:** DONE with out_ready high → IDLE next edge; in_ready goes high in the cycle after the handshake.
- **Partial last step:** when remaining < STEP, the last step shifts by `remaining` only. No over-shift.

## Test plan
- STEP=1, SEXT, amount=8, data=16'h00F3 → result 16'hFFF3; out_valid 17 cycles after accept.
- STEP=1, ZEXT, amount=12, data=16'hABCD → 16'h0BCD with latency 9. SEXT amount=0 → 16'h0000. Mode 6, data=16'h1234 → 16'h1234 with latency 1.
- STEP=4:
  - SAR, amount=3, data=16'h8010 → 16'hF002, latency 2.
  - SHL, amount=20, data=16'h1234 → 16'h0000, latency 5.
  - SHR, amount=6, data=16'hFFFF → 16'h03FF, latency 3.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new data. Required: result and out_valid held, in_ready=0, new request not taken. Raise out_ready: IDLE next edge, then the new request is accepted.
- Reset mid-LEFT phase (SEXT amount=4, STEP=1): pull reset_n low between edges. Required: out_valid=0, result=0, in_ready=1 immediately, without a clock. After release, SHL amount=1 on 16'h4001 → 16'h8002.
- Back-to-back: hold in_valid high for 3 SHL amount=1 ops with out_ready=1. Required: each op accepted every 3 cycles (accept, shift, DONE/release) with correct in-order results.
